// File: rtl/munoc_rlx_master_arbiter_if.sv
// Bundled request/response signals between NUM_REQ local RLX requesters and the shared
// RLX master port. The arbiter takes the master modport and the environment the slave modport.
interface munoc_rlx_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned BW_ADDR = 32,
  parameter int unsigned BW_DATA = 32
);
  logic [NUM_REQ-1:0]           req_qvalid;
  logic [NUM_REQ-1:0]           req_qready;
  logic [NUM_REQ-1:0]           req_qlast;
  logic [NUM_REQ-1:0]           req_qwrite;
  logic [NUM_REQ*8-1:0]         req_qlen;
  logic [NUM_REQ*3-1:0]         req_qsize;
  logic [NUM_REQ*2-1:0]         req_qburst;
  logic [NUM_REQ*BW_DATA/8-1:0] req_qwstrb;
  logic [NUM_REQ*BW_DATA-1:0]   req_qwdata;
  logic [NUM_REQ*BW_ADDR-1:0]   req_qaddr;
  logic [NUM_REQ-1:0]           req_yvalid;
  logic [NUM_REQ-1:0]           req_yready;
  logic                         req_ylast;
  logic                         req_ywreply;
  logic [1:0]                   req_yresp;
  logic [BW_DATA-1:0]           req_yrdata;

  logic                         mst_qvalid;
  logic                         mst_qready;
  logic                         mst_qlast;
  logic                         mst_qwrite;
  logic [7:0]                   mst_qlen;
  logic [2:0]                   mst_qsize;
  logic [1:0]                   mst_qburst;
  logic [BW_DATA/8-1:0]         mst_qwstrb;
  logic [BW_DATA-1:0]           mst_qwdata;
  logic [BW_ADDR-1:0]           mst_qaddr;
  logic                         mst_yvalid;
  logic                         mst_ylast;
  logic                         mst_ywreply;
  logic [1:0]                   mst_yresp;
  logic [BW_DATA-1:0]           mst_yrdata;
  logic                         mst_yready;

  modport master (
    input  req_qvalid, req_qlast, req_qwrite, req_qlen, req_qsize, req_qburst, req_qwstrb,
    input  req_qwdata, req_qaddr, req_yready,
    output req_qready, req_yvalid, req_ylast, req_ywreply, req_yresp, req_yrdata,
    output mst_qvalid, mst_qlast, mst_qwrite, mst_qlen, mst_qsize, mst_qburst, mst_qwstrb,
    output mst_qwdata, mst_qaddr, mst_yready,
    input  mst_qready, mst_yvalid, mst_ylast, mst_ywreply, mst_yresp, mst_yrdata
  );

  modport slave (
    output req_qvalid, req_qlast, req_qwrite, req_qlen, req_qsize, req_qburst, req_qwstrb,
    output req_qwdata, req_qaddr, req_yready,
    input  req_qready, req_yvalid, req_ylast, req_ywreply, req_yresp, req_yrdata,
    input  mst_qvalid, mst_qlast, mst_qwrite, mst_qlen, mst_qsize, mst_qburst, mst_qwstrb,
    input  mst_qwdata, mst_qaddr, mst_yready,
    output mst_qready, mst_yvalid, mst_ylast, mst_ywreply, mst_yresp, mst_yrdata
  );
endinterface

// File: rtl/munoc_rlx_master_arbiter.sv
// Round-robin, packet-granular arbiter sharing one RLX master port between NUM_REQ requesters;
// responses are routed back in order through an ID FIFO.
module munoc_rlx_master_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned BW_ADDR     = 32,
  parameter int unsigned BW_DATA     = 32,
  parameter int unsigned ORDER_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          hold,
  munoc_rlx_master_arbiter_if.master    bus,
  output logic [$clog2(ORDER_DEPTH):0]  outstanding,
  output logic                          stray_resp
);
  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned PtrW   = $clog2(ORDER_DEPTH);
  localparam int unsigned BwStrb = BW_DATA / 8;

  typedef logic [IdW-1:0]  id_t;
  typedef logic [PtrW:0]   cnt_t;
  typedef enum logic {StIdle, StLocked} state_e;

  localparam id_t  LastId   = id_t'(NUM_REQ - 1);
  localparam cnt_t DepthCnt = cnt_t'(ORDER_DEPTH);

  state_e          state_q, state_d;
  id_t             grant_q, grant_d;
  id_t             rr_ptr_q, rr_ptr_d;
  id_t             cand, sel, head;
  logic            cand_valid;
  logic            q_hs, push, pop;
  logic            fifo_full, fifo_empty;
  id_t             fifo_mem_q [ORDER_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  cnt_t            count_q;
  logic            stray_q;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    cand       = rr_ptr_q;
    cand_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!cand_valid && bus.req_qvalid[idx[IdW-1:0]]) begin
        cand_valid = 1'b1;
        cand       = idx[IdW-1:0];
      end
    end
  end

  assign sel = (state_q == StLocked) ? grant_q : cand;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    if (q_hs) begin
      grant_d = sel;
      if (bus.mst_qlast) begin
        state_d  = StIdle;
        push     = 1'b1;
        rr_ptr_d = (sel == LastId) ? '0 : sel + 1'b1;
      end else begin
        state_d = StLocked;
      end
    end
  end

  // A locked packet ignores hold and full: its start was already checked against full.
  always_comb begin
    bus.mst_qvalid = 1'b0;
    bus.req_qready = '0;
    unique case (state_q)
      StIdle:   bus.mst_qvalid = cand_valid & ~hold & ~fifo_full;
      StLocked: bus.mst_qvalid = bus.req_qvalid[grant_q];
    endcase
    bus.req_qready[sel] = bus.mst_qready & bus.mst_qvalid;
  end

  assign q_hs           = bus.mst_qvalid & bus.mst_qready;
  assign bus.mst_qlast  = bus.req_qlast[sel];
  assign bus.mst_qwrite = bus.req_qwrite[sel];
  assign bus.mst_qlen   = bus.req_qlen[sel*8 +: 8];
  assign bus.mst_qsize  = bus.req_qsize[sel*3 +: 3];
  assign bus.mst_qburst = bus.req_qburst[sel*2 +: 2];
  assign bus.mst_qwstrb = bus.req_qwstrb[sel*BwStrb +: BwStrb];
  assign bus.mst_qwdata = bus.req_qwdata[sel*BW_DATA +: BW_DATA];
  assign bus.mst_qaddr  = bus.req_qaddr[sel*BW_ADDR +: BW_ADDR];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DepthCnt);
  assign head       = fifo_mem_q[rd_ptr_q];

  // With nothing outstanding every response beat is accepted and dropped.
  always_comb begin
    bus.req_yvalid = '0;
    bus.mst_yready = 1'b1;
    if (!fifo_empty) begin
      bus.req_yvalid[head] = bus.mst_yvalid;
      bus.mst_yready       = bus.req_yready[head];
    end
  end

  assign pop             = ~fifo_empty & bus.mst_yvalid & bus.mst_yready & bus.mst_ylast;
  assign bus.req_ylast   = bus.mst_ylast;
  assign bus.req_ywreply = bus.mst_ywreply;
  assign bus.req_yresp   = bus.mst_yresp;
  assign bus.req_yrdata  = bus.mst_yrdata;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      for (int i = 0; i < ORDER_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stray_q  <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= sel;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      stray_q <= fifo_empty & bus.mst_yvalid;
    end
  end

  assign outstanding = count_q;
  assign stray_resp  = stray_q;
endmodule

// File: tb/tb_munoc_rlx_master_arbiter.sv
// Directed bench: requester beats and expected master beats / routed responses go into
// scoreboard queues; a monitor pops and compares on every handshake.
module tb_munoc_rlx_master_arbiter;
  localparam int unsigned NR    = 3;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        last;
    logic [7:0]  len;
  } beat_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        last;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rstnn;
  logic       hold;
  logic [2:0] outstanding;
  logic       stray_resp;

  beat_t pend[$];
  beat_t exp_q[$];
  rsp_t  rsp_q[$];
  int    checks = 0;
  int    errors = 0;

  munoc_rlx_master_arbiter_if #(.NUM_REQ(NR), .BW_ADDR(32), .BW_DATA(32)) bus ();

  munoc_rlx_master_arbiter #(
    .NUM_REQ(NR), .BW_ADDR(32), .BW_DATA(32), .ORDER_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstnn(rstnn), .hold(hold), .bus(bus),
    .outstanding(outstanding), .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic write, input logic last, input logic [7:0] len,
                       input bit exp_on);
    beat_t b;
    b.id = id; b.addr = addr; b.wdata = wdata; b.write = write; b.last = last; b.len = len;
    pend.push_back(b);
    if (exp_on) exp_q.push_back(b);
  endtask

  task automatic push_rsp(input int id, input logic [31:0] data, input logic last);
    rsp_t r;
    r.id = id; r.data = data; r.last = last;
    rsp_q.push_back(r);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic rsp_beat(input logic [31:0] data, input logic last);
    logic done;
    done = 1'b0;
    bus.mst_yvalid = 1'b1;
    bus.mst_ylast  = last;
    bus.mst_yrdata = data;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.mst_yready;
    end
    chk("rsp_accept", 64'(done), 64'd1);
    tick();
    bus.mst_yvalid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((pend.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(pend.size() + exp_q.size()), 64'd0);
    tick();
  endtask

  // Requester driver: retire handshaken beats, present each requester's oldest pending beat.
  initial begin
    logic [NR-1:0] hs;
    logic          found;
    bus.req_qvalid = '0; bus.req_qlast = '0; bus.req_qwrite = '0; bus.req_qlen = '0;
    bus.req_qsize  = '0; bus.req_qburst = '0; bus.req_qwstrb = '0; bus.req_qwdata = '0;
    bus.req_qaddr  = '0;
    forever begin
      @(negedge clk);
      hs = bus.req_qvalid & bus.req_qready;
      @(posedge clk);
      #2;
      for (int r = 0; r < NR; r++) begin
        if (hs[r]) begin
          for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].id == r) begin
              pend.delete(i);
              break;
            end
          end
        end
        found = 1'b0;
        for (int i = 0; i < pend.size(); i++) begin
          if (!found && pend[i].id == r) begin
            found = 1'b1;
            bus.req_qlast[r]         = pend[i].last;
            bus.req_qwrite[r]        = pend[i].write;
            bus.req_qlen[r*8 +: 8]   = pend[i].len;
            bus.req_qsize[r*3 +: 3]  = 3'd2;
            bus.req_qburst[r*2 +: 2] = 2'b01;
            bus.req_qwstrb[r*4 +: 4] = pend[i].write ? 4'hF : 4'h0;
            bus.req_qwdata[r*32 +: 32] = pend[i].wdata;
            bus.req_qaddr[r*32 +: 32]  = pend[i].addr;
          end
        end
        bus.req_qvalid[r] = found;
      end
    end
  end

  // Monitor: compare every master-side request beat and every routed response beat.
  initial begin
    beat_t e;
    rsp_t  r;
    forever begin
      @(negedge clk);
      if (rstnn && bus.mst_qvalid && bus.mst_qready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL q_extra: got beat addr %0h required no beat", bus.mst_qaddr);
        end else begin
          e = exp_q.pop_front();
          chk("q_src", 64'(bus.req_qready), 64'(1 << e.id));
          chk("q_addr", 64'(bus.mst_qaddr), 64'(e.addr));
          if (e.write) chk("q_wdata", 64'(bus.mst_qwdata), 64'(e.wdata));
          chk("q_ctl", 64'({bus.mst_qwrite, bus.mst_qlast, bus.mst_qlen, bus.mst_qwstrb}),
              64'({e.write, e.last, e.len, (e.write ? 4'hF : 4'h0)}));
        end
      end
      if (rstnn && (bus.req_yvalid & bus.req_yready) != '0) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL y_extra: got req_yvalid %0h required none", bus.req_yvalid);
        end else begin
          r = rsp_q.pop_front();
          chk("y_dst", 64'(bus.req_yvalid), 64'(1 << r.id));
          chk("y_rdata", 64'(bus.req_yrdata), 64'(r.data));
          chk("y_last", 64'(bus.req_ylast), 64'(r.last));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rstnn = 1'b0; hold = 1'b0;
    bus.req_yready = '1; bus.mst_qready = 1'b0; bus.mst_yvalid = 1'b0; bus.mst_ylast = 1'b0;
    bus.mst_ywreply = 1'b0; bus.mst_yresp = 2'b00; bus.mst_yrdata = '0;
    #3;
    chk("rst_mst_qvalid", 64'(bus.mst_qvalid), 64'd0);
    chk("rst_req_qready", 64'(bus.req_qready), 64'd0);
    chk("rst_req_yvalid", 64'(bus.req_yvalid), 64'd0);
    chk("rst_mst_yready", 64'(bus.mst_yready), 64'd1);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_stray", 64'(stray_resp), 64'd0);
    tick();
    rstnn = 1'b1;
    bus.mst_qready = 1'b1;

    // Two single-beat reads: req0 first, then req1.
    issue(0, 32'h100, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    issue(1, 32'h200, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    wait_drain(20);
    @(negedge clk);
    chk("two_reads_outstanding", 64'(outstanding), 64'd2);
    tick();
    push_rsp(0, 32'hA0, 1'b1); rsp_beat(32'hA0, 1'b1);
    push_rsp(1, 32'hB1, 1'b1); rsp_beat(32'hB1, 1'b1);
    @(negedge clk);
    chk("two_reads_drained", 64'(outstanding), 64'd0);
    tick();

    // 4-beat write from req1 is not interleaved with req0.
    for (int i = 0; i < 4; i++)
      issue(1, 32'h300 + 32'(i * 4), 32'h1111_0000 + 32'(i), 1'b1, (i == 3), 8'd3, 1'b1);
    tick();
    issue(0, 32'h104, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    wait_drain(30);
    push_rsp(1, 32'h0, 1'b1); rsp_beat(32'h0, 1'b1);
    push_rsp(0, 32'hA4, 1'b1); rsp_beat(32'hA4, 1'b1);

    // Full ID FIFO blocks the fifth packet until one response pops.
    for (int i = 0; i < 5; i++) issue(2, 32'h400 + 32'(i * 4), 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    for (int n = 0; n < 40 && exp_q.size() > 1; n++) @(negedge clk);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_mst_qvalid", 64'(bus.mst_qvalid), 64'd0);
      chk("full_outstanding", 64'(outstanding), 64'd4);
      chk("full_pending", 64'(exp_q.size()), 64'd1);
    end
    tick();
    push_rsp(2, 32'hD0, 1'b1); rsp_beat(32'hD0, 1'b1);
    @(negedge clk);
    chk("unfull_mst_qvalid", 64'(bus.mst_qvalid), 64'd1);
    chk("unfull_outstanding", 64'(outstanding), 64'd3);
    tick();
    wait_drain(10);
    for (int i = 0; i < 4; i++) begin
      push_rsp(2, 32'hD1 + 32'(i), 1'b1);
      rsp_beat(32'hD1 + 32'(i), 1'b1);
    end

    // In-order return for IDs {2,0} with requester 2 stalling.
    issue(2, 32'h500, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    tick();
    issue(0, 32'h504, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    wait_drain(20);
    bus.req_yready = 3'b011;
    push_rsp(2, 32'hC2, 1'b1);
    bus.mst_yvalid = 1'b1; bus.mst_ylast = 1'b1; bus.mst_yrdata = 32'hC2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_mst_yready", 64'(bus.mst_yready), 64'd0);
      chk("stall_req_yvalid", 64'(bus.req_yvalid), 64'b100);
    end
    tick();
    bus.req_yready = 3'b111;
    @(negedge clk);
    tick();
    bus.mst_yvalid = 1'b0;
    push_rsp(0, 32'hC0, 1'b0); rsp_beat(32'hC0, 1'b0);
    push_rsp(0, 32'hC1, 1'b1); rsp_beat(32'hC1, 1'b1);
    @(negedge clk);
    chk("inorder_outstanding", 64'(outstanding), 64'd0);
    tick();

    // hold mid-burst: the burst completes, the next packet waits.
    issue(1, 32'h600, 32'h2222_0000, 1'b1, 1'b0, 8'd1, 1'b1);
    issue(1, 32'h604, 32'h2222_0001, 1'b1, 1'b1, 8'd1, 1'b1);
    tick();
    hold = 1'b1;
    issue(0, 32'h608, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    @(negedge clk);
    chk("hold_burst_beat", 64'(bus.mst_qvalid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_mst_qvalid", 64'(bus.mst_qvalid), 64'd0);
      chk("hold_req_qready", 64'(bus.req_qready), 64'd0);
    end
    tick();
    hold = 1'b0;
    wait_drain(10);
    push_rsp(1, 32'h0, 1'b1); rsp_beat(32'h0, 1'b1);
    push_rsp(0, 32'hA8, 1'b1); rsp_beat(32'hA8, 1'b1);

    // Stray response with nothing outstanding.
    bus.mst_yvalid = 1'b1; bus.mst_ylast = 1'b1; bus.mst_yrdata = 32'hDEAD;
    @(negedge clk);
    chk("stray_yready", 64'(bus.mst_yready), 64'd1);
    chk("stray_yvalid", 64'(bus.req_yvalid), 64'd0);
    chk("stray_early", 64'(stray_resp), 64'd0);
    tick();
    bus.mst_yvalid = 1'b0;
    @(negedge clk);
    chk("stray_pulse", 64'(stray_resp), 64'd1);
    @(negedge clk);
    chk("stray_end", 64'(stray_resp), 64'd0);
    tick();

    // Asynchronous reset in the middle of a locked burst.
    issue(2, 32'h700, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    wait_drain(10);
    issue(1, 32'h710, 32'h7777_0000, 1'b1, 1'b0, 8'd1, 1'b1);
    issue(1, 32'h714, 32'h7777_0001, 1'b1, 1'b1, 8'd1, 1'b0);
    @(negedge clk);
    tick();
    bus.mst_qready = 1'b0;
    @(negedge clk);
    chk("locked_mst_qvalid", 64'(bus.mst_qvalid), 64'd1);
    chk("locked_outstanding", 64'(outstanding), 64'd1);
    #2;
    rstnn = 1'b0;
    hold  = 1'b1;
    pend.delete();
    #1;
    chk("arst_mst_qvalid", 64'(bus.mst_qvalid), 64'd0);
    chk("arst_req_qready", 64'(bus.req_qready), 64'd0);
    chk("arst_mst_yready", 64'(bus.mst_yready), 64'd1);
    chk("arst_outstanding", 64'(outstanding), 64'd0);
    tick();
    rstnn = 1'b1;
    tick();
    hold = 1'b0;
    bus.mst_qready = 1'b1;
    issue(0, 32'h800, 32'h0, 1'b0, 1'b1, 8'd0, 1'b1);
    wait_drain(10);
    push_rsp(0, 32'hE0, 1'b1); rsp_beat(32'hE0, 1'b1);
    @(negedge clk);
    chk("post_rst_outstanding", 64'(outstanding), 64'd0);
    chk("req_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("rsp_sb_empty", 64'(rsp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/munoc_rlx_master_arbiter.md
Name: munoc_rlx_master_arbiter

Overview:
- Shares one RLX master port between NUM_REQ local requesters, e.g. a core's instruction and data ports plus a DMA.
- The shared port feeds a single MUNOC XMI master network interface.
- Round-robin arbitration at packet granularity; a write burst is never interleaved.
- Responses return in order and are routed back to the issuing requester through an in-order ID FIFO.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BW_ADDR, 32, address width
BW_DATA, 32, data width; wstrb width is BW_DATA/8
ORDER_DEPTH, 4, maximum outstanding request packets (power of 2, >=2)

Ports:
clk  input  1  clock
rstnn  input  1  asynchronous active-low reset
hold  input  1  blocks start of new packets; an in-progress packet completes
req_qvalid  input  NUM_REQ  per-requester request valid
req_qready  output  NUM_REQ  per-requester request ready
req_qlast  input  NUM_REQ  last beat of request packet
req_qwrite  input  NUM_REQ  1=write
req_qlen  input  NUM_REQ*8  AXI len
req_qsize  input  NUM_REQ*3  AXI size
req_qburst  input  NUM_REQ*2  AXI burst
req_qwstrb  input  NUM_REQ*BW_DATA/8  write strobes
req_qwdata  input  NUM_REQ*BW_DATA  write data
req_qaddr  input  NUM_REQ*BW_ADDR  address
req_yvalid  output  NUM_REQ  per-requester response valid
req_yready  input  NUM_REQ  per-requester response ready
req_ylast, req_ywreply  output  1 each  broadcast response fields
req_yresp  output  2  broadcast response code
req_yrdata  output  BW_DATA  broadcast read data
mst_qvalid  output  1  shared request valid
mst_qready  input  1  shared request ready
mst_qlast, mst_qwrite, mst_qlen, mst_qsize, mst_qburst, mst_qwstrb, mst_qwdata, mst_qaddr  output  as per-requester slice  muxed request fields
mst_yvalid, mst_ylast, mst_ywreply  input  1 each  shared response
mst_yresp  input  2  shared response code
mst_yrdata  input  BW_DATA  shared read data
mst_yready  output  1  shared response ready
outstanding  output  log2(ORDER_DEPTH)+1  ID FIFO occupancy
stray_resp  output  1  one-cycle pulse: response received with no outstanding packet

Behaviour:
- Reset (async, rstnn=0): lock=0, grant=0, rr_ptr=0, FIFO empty, outstanding=0, stray_resp=0. All valid/ready outputs are 0 except mst_yready, which is 1 because the FIFO is empty.
- Request path is combinational, with zero latency from req to mst. Data fields are the muxed slice of the current grant.
- Unlocked state:
  - The candidate is the first requester with qvalid set, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - mst_qvalid = candidate exists & ~hold & ~fifo_full.
  - req_qready[candidate] = mst_qready & mst_qvalid. All other req_qready are 0.
- Handshake of a non-last beat: lock=1, grant=candidate.
- Locked state:
  - Only grant is served. hold and fifo_full are ignored.
  - Other requesters see qready=0.
- Handshake of a last beat (locked or unlocked):
  - lock=0.
  - Push grant ID into the FIFO.
  - rr_ptr = (grant+1) mod NUM_REQ.
- A single-beat packet (qlast=1 on the first beat) never sets lock.
- Read requests carry qlast=1.
- A full FIFO blocks only packet start. A locked packet always fits because its start was checked against full.
- Response path:
  - With the FIFO non-empty, head = FIFO head ID.
  - req_yvalid[head] = mst_yvalid; all other req_yvalid are 0.
  - mst_yready = req_yready[head].
  - On a handshake with mst_ylast=1, pop the FIFO.
- With the FIFO empty, mst_yready=1 and req_yvalid=0. A beat with mst_yvalid=1 is dropped, and stray_resp pulses 1 on the following cycle.
- Simultaneous push and pop in one cycle: occupancy unchanged, and both operations are applied.
- outstanding = push count minus pop count, range 0..ORDER_DEPTH.
- The FIFO pointers wrap modulo ORDER_DEPTH.

Test Plan:
- Reset, then req0 and req1 both issue single-beat reads with mst_qready=1 -> req0 granted in cycle 0 and req1 in cycle 1; FIFO holds {0,1}; outstanding=2.
- req1 issues a 4-beat write while req0 is valid throughout -> mst carries beats 1..4 of req1 back-to-back; req0 qready=0 until after req1's last beat; req0 is then granted.
- Issue 4 reads (ORDER_DEPTH=4) with no responses, then a 5th request -> mst_qvalid=0 and outstanding=4. One response with ylast=1 arrives -> the 5th request is granted on the next cycle.
- Responses return in order for IDs {2,0} with req_yready[2]=0 for 3 cycles -> mst_yready=0 for those 3 cycles; req_yvalid[0] stays 0 until ID 2 pops.
- Assert hold mid-burst of a 2-beat write -> the burst completes; a new packet waits until hold=0.
- mst_yvalid=1 with an empty FIFO -> beat dropped, stray_resp=1 for one cycle. Assert rstnn=0 mid-burst -> all outputs return to reset values immediately.
